yannickreiss_dot_seq: RTL and testbench

YANNICKREISS_DOT_SEQ -- requirements
Module: yannickreiss_dot_seq

---
 rtl/yannickreiss_dot_pkg.sv | 19 +
 rtl/yannickreiss_dot_step.sv | 53 +++++
 rtl/yannickreiss_dot_seq.sv | 109 ++++++++++
 tb/tb_yannickreiss_dot_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/yannickreiss_dot_pkg.sv
// Shared constants for the sequential 3-bit multiply/divide unit.
// State encoding, opcodes and datapath widths.
package yannickreiss_dot_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 6;
  localparam int ITER = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_LOAD_B = 2'b01;
  localparam state_t ST_RUN    = 2'b10;
  localparam state_t ST_DONE   = 2'b11;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/yannickreiss_dot_step.sv
// One combinational iteration: shift-add multiply (LSB first)
// or restoring divide (MSB first).
module yannickreiss_dot_step
  import yannickreiss_dot_pkg::*;
(
  input  logic            op,
  input  logic [RESW-1:0] acc,
  input  logic [OPW-1:0]  rem,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [1:0]      idx,
  output logic [RESW-1:0] acc_nxt,
  output logic [OPW-1:0]  rem_nxt,
  output logic            q_bit
);

  logic [1:0]      msb_idx;
  logic [OPW-1:0]  a_sh;
  logic [OPW-1:0]  b_sh;
  logic [OPW:0]    shifted;
  logic [OPW:0]    b_ext;
  logic [RESW-1:0] addend;

  always_comb begin
    msb_idx = 2'(OPW - 1) - idx;
    a_sh    = a >> msb_idx;
    b_sh    = b >> idx;
    shifted = {rem, a_sh[0]};
    b_ext   = {1'b0, b};
    addend  = b_sh[0] ? (RESW'(a) << idx) : '0;
    acc_nxt = acc;
    rem_nxt = rem;
    q_bit   = 1'b0;
    unique case (1'b1)
      (op == OP_MUL): begin
        acc_nxt = acc + addend;
      end
      (op == OP_DIV): begin
        // divide by zero yields all-zero quotient and remainder
        if (b == '0) begin
          rem_nxt = '0;
        end else if (shifted >= b_ext) begin
          rem_nxt = OPW'(shifted - b_ext);
          q_bit   = 1'b1;
        end else begin
          rem_nxt = shifted[OPW-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/yannickreiss_dot_seq.sv
// Sequential 3-bit multiply/divide with load/ack handshake
// on big-endian 8-bit pin buses.
module yannickreiss_dot_seq
  import yannickreiss_dot_pkg::*;
(
  input  logic [0:7] io_in,
  output logic [0:7] io_out
);

  logic           clk;
  logic           rst_n;
  logic           op_code;
  logic           load;
  logic           ack;
  logic [OPW-1:0] data;

  assign clk     = io_in[0];
  assign rst_n   = io_in[1];
  assign op_code = io_in[2];
  assign load    = io_in[3];
  assign ack     = io_in[4];
  assign data    = io_in[5:7];

  state_t          state;
  logic            op_q;
  logic [OPW-1:0]  a_q;
  logic [OPW-1:0]  b_q;
  logic [1:0]      cnt;
  logic [RESW-1:0] acc;
  logic [OPW-1:0]  rem;
  logic [RESW-1:0] res;

  logic [RESW-1:0] acc_nxt;
  logic [OPW-1:0]  rem_nxt;
  logic            q_bit;
  logic [RESW-1:0] acc_upd;

  yannickreiss_dot_step u_step (
    .op      (op_q),
    .acc     (acc),
    .rem     (rem),
    .a       (a_q),
    .b       (b_q),
    .idx     (cnt),
    .acc_nxt (acc_nxt),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // divide shifts quotient bits into the accumulator
  assign acc_upd = (op_q == OP_DIV)
                 ? {acc[RESW-2:0], q_bit}
                 : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      acc   <= '0;
      rem   <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            a_q   <= data;
            op_q  <= op_code;
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (load) begin
            b_q   <= data;
            cnt   <= '0;
            acc   <= '0;
            rem   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_upd;
          rem <= rem_nxt;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(ITER - 1)) begin
            res   <= (op_q == OP_DIV)
                   ? {acc_upd[OPW-1:0], rem_nxt}
                   : acc_upd;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io_out[0:5] = res;
  assign io_out[6]   = (state == ST_LOAD_B)
                     | (state == ST_RUN);
  assign io_out[7]   = (state == ST_DONE);

endmodule

// File: tb/tb_yannickreiss_dot_seq.sv
// Directed bench for yannickreiss_dot_seq.
// Hand-computed vectors plus an exhaustive reference sweep.
module tb_yannickreiss_dot_seq;

  logic       clk;
  logic       rst_n;
  logic       op_code;
  logic       load;
  logic       ack;
  logic [2:0] data;
  logic [0:7] io_in;
  logic [0:7] io_out;

  logic [5:0] res;
  logic       busy;
  logic       done;
  logic [5:0] prev_res;

  int n_chk;
  int n_fail;

  assign io_in = {clk, rst_n, op_code, load, ack, data};
  assign res   = io_out[0:5];
  assign busy  = io_out[6];
  assign done  = io_out[7];

  yannickreiss_dot_seq dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ref_model(input logic o,
                                           input logic [2:0] a,
                                           input logic [2:0] b);
    logic [2:0] q;
    logic [2:0] r;
    if (!o) return 6'(a) * 6'(b);
    if (b == 3'd0) return 6'd0;
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  task automatic start_op(input logic o,
                          input logic [2:0] a,
                          input logic [2:0] b);
    op_code = o;
    load    = 1'b1;
    data    = a;
    tick();
    data = b;
    tick();
    load = 1'b0;
  endtask

  task automatic finish_op(input string tag,
                           input logic [5:0] exp);
    tick();
    tick();
    check({tag, "_run"}, {busy, done}, 8'b10);
    check({tag, "_hold"}, res, prev_res);
    tick();
    check({tag, "_done"}, {busy, done}, 8'b01);
    check({tag, "_res"}, res, exp);
    prev_res = exp;
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_ack"}, {busy, done}, 8'b00);
    check({tag, "_keep"}, res, prev_res);
  endtask

  task automatic run_op(input logic o,
                        input logic [2:0] a,
                        input logic [2:0] b,
                        input string tag);
    start_op(o, a, b);
    finish_op(tag, ref_model(o, a, b));
    do_ack(tag);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    prev_res = '0;
    rst_n    = 1'b1;
    op_code  = 1'b0;
    load     = 1'b0;
    ack      = 1'b0;
    data     = 3'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", io_out, 8'h00);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("rst_idle", io_out, 8'h00);

    // multiply 3*5 with explicit latency checks
    op_code = 1'b0;
    load    = 1'b1;
    data    = 3'd3;
    tick();
    check("mul_a_busy", {busy, done}, 8'b10);
    data = 3'd5;
    tick();
    load = 1'b0;
    check("mul_b_busy", {busy, done}, 8'b10);
    finish_op("mul35", 6'b001111);
    ack = 1'b0;
    tick();
    check("mul_hold_done", {busy, done}, 8'b01);
    do_ack("mul35");

    // ack ignored outside DONE
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_idle", {busy, done}, 8'b00);

    run_op(1'b1, 3'd7, 3'd2, "div72");
    check("div72_val", res, 8'b011001);
    run_op(1'b1, 3'd6, 3'd3, "div63");
    check("div63_val", res, 8'b010000);
    run_op(1'b1, 3'd5, 3'd0, "div50");
    check("div50_val", res, 8'b000000);

    // ack wins over load in DONE
    start_op(1'b0, 3'd2, 3'd3);
    finish_op("prio", 6'd6);
    ack  = 1'b1;
    load = 1'b1;
    data = 3'd5;
    tick();
    ack = 1'b0;
    check("prio_idle", {busy, done}, 8'b00);
    data = 3'd4;
    tick();
    check("prio_newa", {busy, done}, 8'b10);
    data = 3'd3;
    tick();
    load = 1'b0;
    finish_op("prio_mul", 6'd12);
    do_ack("prio_mul");

    // asynchronous reset in the second RUN cycle
    start_op(1'b0, 3'd7, 3'd7);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst", io_out, 8'h00);
    prev_res = '0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("midrun_rel", io_out, 8'h00);
    run_op(1'b0, 3'd7, 3'd7, "mul77");
    check("mul77_val", res, 8'b110001);

    // held load captures A then B with the same data
    op_code = 1'b0;
    load    = 1'b1;
    data    = 3'd6;
    tick();
    check("held_a", {busy, done}, 8'b10);
    tick();
    check("held_b", {busy, done}, 8'b10);
    finish_op("held", 6'd36);
    tick();
    check("held_ignored", {busy, done}, 8'b01);
    load = 1'b0;
    do_ack("held");

    for (int o = 0; o < 2; o++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          run_op(o[0], a[2:0], b[2:0],
                 $sformatf("exh_o%0d_a%0d_b%0d", o, a, b));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
